// File: rtl/mm2s_dispatch.sv
// mm2s_dispatch: tag-driven scheduler between the MM2S prefetch buffer and
// the internal consumer ports. One tag is popped at a time; exactly
// (tag[15:0] + 1) data beats are then forwarded to the port selected by the
// tag destination. tlast is regenerated from the internal beat count, input
// tlast is only used for a sticky framing check, and free-running performance
// counters are exported through a registered status word.
//
// Handshake semantics (all streams): a transfer happens on a rising clk edge
// where valid and ready are both high. Valid never waits for ready. The data
// path is combinational: m_tvalid[dst] follows s_data_tvalid and
// s_data_tready follows m_tready[dst], so consumers must not derive ready
// from valid combinationally. While rst is high every ready and valid output
// is held low.
module mm2s_dispatch #(
    parameter int AXI_DATA_WIDTH = 512,
    parameter int MM2S_TAG_WIDTH = 32,
    parameter int N_DEST         = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    // tag stream from the prefetch tag FIFO
    input  logic                          s_tag_tvalid,
    output logic                          s_tag_tready,
    input  logic [MM2S_TAG_WIDTH-1:0]     s_tag_tdata,
    input  logic [1:0]                    s_tag_tdest,
    // data stream from the prefetch data FIFO
    input  logic                          s_data_tvalid,
    output logic                          s_data_tready,
    input  logic [AXI_DATA_WIDTH-1:0]     s_data_tdata,
    input  logic [AXI_DATA_WIDTH/8-1:0]   s_data_tkeep,
    input  logic                          s_data_tlast,
    // consumer ports; data/keep/last are shared, valid/ready are per port
    output logic [N_DEST-1:0]             m_tvalid,
    input  logic [N_DEST-1:0]             m_tready,
    output logic [AXI_DATA_WIDTH-1:0]     m_tdata,
    output logic [AXI_DATA_WIDTH/8-1:0]   m_tkeep,
    output logic                          m_tlast,
    // status
    output logic                          busy,
    output logic [4*32-1:0]               status,
    output logic                          dbg_state
);

    localparam int DEST_W = 2;
    localparam int CNT_W  = 16;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DEST_W-1:0]   dst_q, dst_d;

    logic [31:0]         beats_q, beats_d;
    logic [31:0]         tags_q, tags_d;
    logic [31:0]         stall_q, stall_d;
    logic                err_q, err_d;
    logic [4*32-1:0]     status_q, status_d;

    logic [N_DEST-1:0]   dest_sel;
    logic                sel_ready;
    logic                last_beat;
    logic                beat_fire;
    logic                tag_done;
    logic                stall_cycle;
    logic                frame_err;

    // Upper tag bits carry no meaning for this block.
    generate
        if (MM2S_TAG_WIDTH > CNT_W) begin : g_tag_hi
            logic tag_hi_unused;
            assign tag_hi_unused = ^s_tag_tdata[MM2S_TAG_WIDTH-1:CNT_W];
        end
    endgenerate

    // One-hot decode of the latched destination; an index beyond N_DEST
    // selects no port and the transfer simply waits.
    always_comb begin
        dest_sel = '0;
        for (int d = 0; d < N_DEST; d++) begin
            dest_sel[d] = (dst_q == DEST_W'(d));
        end
    end

    assign sel_ready = |(m_tready & dest_sel);
    assign last_beat = (cnt_q == '0);

    // Shared data fields pass straight through; only valid is steered.
    assign m_tdata   = s_data_tdata;
    assign m_tkeep   = s_data_tkeep;
    assign busy      = (state_q == XFER);
    assign dbg_state = state_q;
    assign status    = status_q;

    // FSM next state, handshakes and per-cycle event strobes.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        dst_d         = dst_q;
        s_tag_tready  = 1'b0;
        s_data_tready = 1'b0;
        m_tvalid      = '0;
        m_tlast       = 1'b0;
        beat_fire     = 1'b0;
        tag_done      = 1'b0;
        stall_cycle   = 1'b0;
        frame_err     = 1'b0;

        case (state_q)
            IDLE: begin
                s_tag_tready = en & ~rst;
                if (s_tag_tvalid && s_tag_tready) begin
                    cnt_d   = s_tag_tdata[CNT_W-1:0];
                    dst_d   = s_tag_tdest;
                    state_d = XFER;
                end
            end
            XFER: begin
                m_tvalid      = dest_sel & {N_DEST{s_data_tvalid & ~rst}};
                s_data_tready = sel_ready & ~rst;
                m_tlast       = last_beat;
                beat_fire     = s_data_tvalid & s_data_tready;
                if (beat_fire) begin
                    // Framing is reported, never obeyed: cnt owns the frame.
                    frame_err = (s_data_tlast != last_beat);
                    if (last_beat) begin
                        tag_done = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end else begin
                    stall_cycle = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Performance counters wrap naturally; the framing flag is sticky.
    always_comb begin
        beats_d  = beats_q + {31'd0, beat_fire};
        tags_d   = tags_q + {31'd0, tag_done};
        stall_d  = stall_q + {31'd0, stall_cycle};
        err_d    = err_q | frame_err;
        status_d = {31'd0, err_q, stall_q, tags_q, beats_q};
    end

    // FSM state, beat count and destination registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dst_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dst_q   <= dst_d;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            beats_q <= '0;
            tags_q  <= '0;
            stall_q <= '0;
            err_q   <= 1'b0;
        end else begin
            beats_q <= beats_d;
            tags_q  <= tags_d;
            stall_q <= stall_d;
            err_q   <= err_d;
        end
    end

    // Status snapshot, one cycle behind the counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            status_q <= '0;
        end else begin
            status_q <= status_d;
        end
    end

endmodule

// File: tb/tb_mm2s_dispatch.sv
// Bench for mm2s_dispatch: queue-backed upstream FIFOs, a scoreboard of
// expected beats pushed at stimulus time, and a transaction-level model of
// the counters built from observed tag/beat handshakes.
module tb_mm2s_dispatch;

    localparam int DW = 32;
    localparam int KW = DW / 8;
    localparam int TW = 32;
    localparam int ND = 4;
    localparam int EW = 2 + 1 + KW + DW;   // {dest, last, keep, data}
    localparam int SW = 1 + KW + DW;       // {tlast_in, keep, data}

    logic            clk = 1'b0;
    logic            rst;
    logic            en;
    logic            s_tag_tvalid;
    logic            s_tag_tready;
    logic [TW-1:0]   s_tag_tdata;
    logic [1:0]      s_tag_tdest;
    logic            s_data_tvalid;
    logic            s_data_tready;
    logic [DW-1:0]   s_data_tdata;
    logic [KW-1:0]   s_data_tkeep;
    logic            s_data_tlast;
    logic [ND-1:0]   m_tvalid;
    logic [ND-1:0]   m_tready;
    logic [DW-1:0]   m_tdata;
    logic [KW-1:0]   m_tkeep;
    logic            m_tlast;
    logic            busy;
    logic [127:0]    status;
    logic            dbg_state;

    mm2s_dispatch #(
        .AXI_DATA_WIDTH(DW),
        .MM2S_TAG_WIDTH(TW),
        .N_DEST(ND)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .s_tag_tvalid(s_tag_tvalid), .s_tag_tready(s_tag_tready),
        .s_tag_tdata(s_tag_tdata), .s_tag_tdest(s_tag_tdest),
        .s_data_tvalid(s_data_tvalid), .s_data_tready(s_data_tready),
        .s_data_tdata(s_data_tdata), .s_data_tkeep(s_data_tkeep),
        .s_data_tlast(s_data_tlast),
        .m_tvalid(m_tvalid), .m_tready(m_tready),
        .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast),
        .busy(busy), .status(status), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- queues and model state ----------------
    logic [17:0]   tag_q[$];
    logic [SW-1:0] dat_q[$];
    logic [EW-1:0] exp_q[$];

    int          checks = 0;
    int          failures = 0;
    logic [31:0] mdl_beats = '0;
    logic [31:0] mdl_tags = '0;
    logic [31:0] mdl_stall = '0;
    logic        mdl_err = 1'b0;
    logic        in_xfer = 1'b0;
    int          rem = 0;
    bit          rnd_ready = 1'b0;
    bit          rnd_gap = 1'b0;
    bit          tag_fire_s = 1'b0;
    bit          data_fire_s = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_status(input string pfx, input int b, input int t, input int s, input int e);
        check({pfx, "_beats"}, status[31:0], 128'(b));
        check({pfx, "_tags"}, status[63:32], 128'(t));
        check({pfx, "_stall"}, status[95:64], 128'(s));
        check({pfx, "_err"}, status[127:96], 128'(e));
    endtask

    // ---------------- driver tasks ----------------
    // Queue one tag and its beats; bad_idx >= 0 puts input tlast on that beat.
    task automatic push_tag(input int dest, input int n_m1, input int bad_idx);
        logic [1:0]    d2;
        logic [15:0]   n16;
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          lin;
        logic          lexp;
        d2  = dest[1:0];
        n16 = n_m1[15:0];
        tag_q.push_back({d2, n16});
        for (int i = 0; i <= n_m1; i++) begin
            data = $urandom;
            keep = KW'($urandom);
            lexp = (i == n_m1);
            lin  = (bad_idx >= 0) ? (i == bad_idx) : lexp;
            dat_q.push_back({lin, keep, data});
            exp_q.push_back({d2, lexp, keep, data});
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int limit);
        int k;
        for (k = 0; k < limit; k++) begin
            @(posedge clk); #2;
            if (tag_q.size() == 0 && exp_q.size() == 0 && !in_xfer) break;
        end
        check({name, "_done_in_time"}, 128'(k < limit), 128'(1));
        repeat (3) @(posedge clk);
        #2;
    endtask

    // ---------------- monitor / model / upstream FIFO driver ----------------
    initial begin
        logic [ND-1:0] hs;
        logic [1:0]    act_dest;
        logic [EW-1:0] e;
        logic [15:0]   hi;
        logic [ND-1:0] rr;
        forever begin
            @(negedge clk);
            if (rst) begin
                check("valid_low_in_reset", 128'(m_tvalid), 128'(0));
                tag_q.delete();
                dat_q.delete();
                exp_q.delete();
                mdl_beats = '0; mdl_tags = '0; mdl_stall = '0; mdl_err = 1'b0;
                in_xfer = 1'b0;
                rem = 0;
                tag_fire_s = 1'b0;
                data_fire_s = 1'b0;
            end else begin
                hs = m_tvalid & m_tready;
                tag_fire_s  = s_tag_tvalid & s_tag_tready;
                data_fire_s = s_data_tvalid & s_data_tready;
                if (m_tvalid != '0) check("valid_onehot", 128'($countones(m_tvalid)), 128'(1));
                if (in_xfer) begin
                    if (hs != '0) begin
                        act_dest = 2'd0;
                        for (int d = 0; d < ND; d++) if (hs[d]) act_dest = 2'(d);
                        if (exp_q.size() == 0) begin
                            check("unexpected_beat", 128'(1), 128'(0));
                        end else begin
                            e = exp_q.pop_front();
                            check("beat", {act_dest, m_tlast, m_tkeep, m_tdata}, 128'(e));
                            if (dat_q.size() > 0 && dat_q[0][SW-1] != e[EW-3]) mdl_err = 1'b1;
                        end
                        mdl_beats++;
                        rem--;
                        if (rem == 0) begin
                            in_xfer = 1'b0;
                            mdl_tags++;
                        end
                    end else begin
                        mdl_stall++;
                    end
                end else if (hs != '0) begin
                    check("beat_outside_transfer", 128'(hs), 128'(0));
                end
                if (tag_fire_s && tag_q.size() > 0) begin
                    in_xfer = 1'b1;
                    rem = int'(tag_q[0][15:0]) + 1;
                end
            end

            @(posedge clk); #1;
            if (tag_fire_s && tag_q.size() > 0) void'(tag_q.pop_front());
            if (data_fire_s && dat_q.size() > 0) void'(dat_q.pop_front());
            if (tag_q.size() > 0) begin
                if (!s_tag_tvalid || tag_fire_s) begin
                    hi = 16'($urandom);
                    s_tag_tdata = {hi, tag_q[0][15:0]};
                end else begin
                    s_tag_tdata[15:0] = tag_q[0][15:0];
                end
                s_tag_tdest  = tag_q[0][17:16];
                s_tag_tvalid = 1'b1;
            end else begin
                s_tag_tvalid = 1'b0;
            end
            if (dat_q.size() > 0) begin
                if (!(s_data_tvalid && !data_fire_s)) begin
                    if (!rnd_gap || $urandom_range(0, 3) != 0) begin
                        {s_data_tlast, s_data_tkeep, s_data_tdata} = dat_q[0];
                        s_data_tvalid = 1'b1;
                    end else begin
                        s_data_tvalid = 1'b0;
                    end
                end
            end else begin
                s_data_tvalid = 1'b0;
            end
            if (rnd_ready) begin
                rr = ND'($urandom);
                m_tready = rr;
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #1500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        int n;
        int bad;
        rst = 1'b1; en = 1'b1;
        s_tag_tvalid = 1'b0; s_tag_tdata = '0; s_tag_tdest = '0;
        s_data_tvalid = 1'b0; s_data_tdata = '0; s_data_tkeep = '0; s_data_tlast = 1'b0;
        m_tready = '1;

        // reset state, with en already high
        repeat (3) @(posedge clk);
        #2;
        check("rst_status", status, 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_tag_ready", 128'(s_tag_tready), 128'(0));
        check("rst_data_ready", 128'(s_data_tready), 128'(0));
        rst = 1'b0;

        // basic transfer
        do_reset();
        push_tag(2, 3, -1);
        wait_idle("basic", 200);
        check_status("basic", 4, 1, 0, 0);

        // backpressure, ready high on the first transfer cycle then toggling
        do_reset();
        m_tready = '0;
        push_tag(1, 7, -1);
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #2;
            m_tready = (k % 2 == 0) ? '1 : '0;
        end
        m_tready = '1;
        wait_idle("bp", 200);
        check_status("bp", 8, 1, 7, 0);

        // back-to-back tags
        do_reset();
        push_tag(0, 0, -1);
        push_tag(3, 1, -1);
        wait_idle("b2b", 200);
        check_status("b2b", 3, 2, 0, 0);

        // framing error, then a clean tag: error stays set
        do_reset();
        push_tag(1, 2, 1);
        wait_idle("frame", 200);
        check_status("frame", 3, 1, 0, 1);
        push_tag(0, 1, -1);
        wait_idle("frame2", 200);
        check_status("frame_sticky", 5, 2, 0, 1);

        // enable gating
        do_reset();
        en = 1'b0;
        push_tag(2, 3, -1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("en_block", 128'(s_tag_tready), 128'(0));
        end
        @(posedge clk); #2;
        en = 1'b1;
        @(negedge clk);
        check("en_accept_same_cycle", 128'(s_tag_tvalid & s_tag_tready), 128'(1));
        @(posedge clk); #2;
        en = 1'b0;
        wait_idle("en", 200);
        check_status("en", 4, 1, 0, 0);
        en = 1'b1;

        // reset after 2 of 5 beats
        do_reset();
        push_tag(1, 4, -1);
        begin
            int k;
            for (k = 0; k < 50; k++) begin
                @(posedge clk); #2;
                if (mdl_beats == 32'd2) break;
            end
            check("mid_two_beats_seen", 128'(k < 50), 128'(1));
        end
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        check("mid_rst_valid", 128'(m_tvalid), 128'(0));
        check("mid_rst_busy", 128'(busy), 128'(0));
        check("mid_rst_status", status, 128'(0));
        push_tag(1, 0, -1);
        wait_idle("post_rst", 200);
        check_status("post_rst", 1, 1, 0, 0);

        // maximum tag field: 65536 beats
        do_reset();
        push_tag(3, 65535, -1);
        wait_idle("max", 70000);
        check_status("max", 65536, 1, 0, 0);

        // randomized traffic against the model
        do_reset();
        rnd_ready = 1'b1;
        rnd_gap = 1'b1;
        for (int t = 0; t < 40; t++) begin
            n = ($urandom_range(0, 7) == 0) ? $urandom_range(8, 24) : $urandom_range(0, 3);
            bad = (n > 0 && $urandom_range(0, 9) == 0) ? $urandom_range(0, n - 1) : -1;
            push_tag($urandom_range(0, 3), n, bad);
        end
        wait_idle("rnd", 20000);
        rnd_ready = 1'b0;
        m_tready = '1;
        check("rnd_beats", status[31:0], 128'(mdl_beats));
        check("rnd_tags", status[63:32], 128'(mdl_tags));
        check("rnd_stall", status[95:64], 128'(mdl_stall));
        check("rnd_err", status[127:96], 128'(mdl_err));
        check("rnd_tags_all", 128'(mdl_tags), 128'(40));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mm2s_dispatch.md
# mm2s_dispatch

Tag-driven scheduler between the MM2S prefetch buffer and the internal consumers (input, weight, bias, instruction paths). It pops one transfer tag at a time, then forwards exactly the tagged number of data beats to the destination port the tag selects. It regenerates `tlast` from its own beat count, flags framing mismatches, and exports performance counters for the layer status registers.

## Interface

Parameters:
- AXI_DATA_WIDTH, 512, data beat width in bits; `tkeep` is AXI_DATA_WIDTH/8.
- MM2S_TAG_WIDTH, 32, tag width in bits; must be ≥16.
- N_DEST, 4, number of consumer ports; destination index width is 2.

Ports:
- clk  in  1  clock; the single clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  layer running; a new tag is accepted only while high.
- s_tag_tvalid / s_tag_tready  in/out  1/1  tag stream from the prefetch tag FIFO.
- s_tag_tdata  in  MM2S_TAG_WIDTH  bits [15:0] hold beats−1; upper bits are ignored.
- s_tag_tdest  in  2  destination port index.
- s_data_tvalid / s_data_tready  in/out  1/1  data stream from the prefetch data FIFO.
- s_data_tdata, s_data_tkeep, s_data_tlast  in  AXI_DATA_WIDTH, /8, 1  data beat fields.
- m_tvalid  out  N_DEST  per-destination valid.
- m_tready  in  N_DEST  per-destination ready.
- m_tdata, m_tkeep  out  AXI_DATA_WIDTH, /8  shared across all destinations.
- m_tlast  out  1  generated last-beat flag.
- busy  out  1  high while in XFER.
- status  out  4×32  [0] beats forwarded, [1] tags completed, [2] stall cycles, [3] bit0 = sticky framing error, bits [31:1] = 0.

## Operation

- FSM states: IDLE and XFER.
- **IDLE**
  - `s_tag_tready = en`; `s_data_tready = 0`; all `m_tvalid = 0`.
  - On a tag handshake: latch `cnt ← tdata[15:0]` and `dst ← tdest`, then go to XFER.
- **XFER**
  - `s_tag_tready = 0`.
  - `m_tvalid[dst] = s_data_tvalid`; the other m_tvalid bits are 0.
  - `s_data_tready = m_tready[dst]`.
  - `m_tdata` and `m_tkeep` pass through combinationally.
  - `m_tlast = (cnt == 0)`.
  - Beat handshake (`s_data_tvalid & s_data_tready`):
    - if `cnt != 0`: `cnt ← cnt − 1`;
    - if `cnt == 0`: return to IDLE and increment the tag counter.
- `en` falling during XFER does not abort the transfer; it only blocks the next tag.
- Framing check, evaluated on each beat handshake:
  - error if `s_data_tlast != (cnt == 0)`;
  - sets sticky error bit 0; cleared only by rst;
  - the beat is still forwarded, and the FSM follows `cnt`, not the input tlast.
- Counters: 32-bit, wrap modulo 2^32, no saturation.
  - Beats: +1 per forwarded beat.
  - Tags: +1 per completed tag.
  - Stall: +1 each cycle in XFER without a beat handshake (either side not ready).
- Arithmetic: `cnt` is 16 bits, so a tag field of 0xFFFF gives 65536 beats. A field of 0 gives exactly one beat.

## Timing

- Reset (rst high at a clock edge):
  - state ← IDLE; `cnt`, `dst` ← 0; all counters ← 0; status ← 0.
  - From the next cycle: `m_tvalid = 0`, `s_*_tready = 0` until rst is low, `busy = 0`.
- Reset mid-XFER: the transfer is abandoned, remaining beats are left in the upstream FIFO, and no outputs glitch after the edge.
- Tag-to-first-beat: the tag is accepted in cycle T; the first beat can be forwarded in T+1. This gives one bubble cycle per tag.
- Last beat in cycle T: IDLE in T+1, next tag accepted in T+1, next first beat at T+2.
- Data path latency is 0 cycles (combinational). The valid→ready path from m_tready to s_data_tready is combinational; consumers must not make ready depend on valid combinationally.
- status is registered: each counter's value appears on status one cycle after it updates.
- Simultaneous events:
  - a tag arriving while in XFER waits;
  - a data beat presented in IDLE waits, since `s_data_tready = 0`;
  - rst overrides everything.
- AXIS rule: once `m_tvalid[dst]` is high, data stays stable until handshake. This holds because the upstream FIFO obeys the same rule and `dst` is constant in XFER.

## Test plan

- **Basic transfer:** tag beats−1 = 3, dest = 2, data always valid, m_tready all 1.
  - Exactly 4 beats on `m_tvalid[2]`; m_tlast on the 4th only.
  - status[0] = 4, status[1] = 1, status[2] = 0; error = 0.
- **Backpressure:** tag beats−1 = 7, dest = 1, m_tready[1] toggling 1,0 every cycle.
  - 8 beats delivered in order, no duplicate or drop.
  - status[2] = number of ready-low XFER cycles (7).
- **Back-to-back tags:** tags (0, dest 0) then (1, dest 3), both queued.
  - 1 beat on port 0, one bubble cycle, 2 beats on port 3.
  - Tag counter = 2; port 0 never valid during the second tag.
- **Framing error:** tag beats−1 = 2 with input tlast on beat 2 instead of 3.
  - Still 3 beats forwarded; m_tlast on beat 3; status[3] = 1 and stays 1.
- **Enable gating:** en = 0 with a tag valid.
  - s_tag_tready = 0 for 10 cycles; raising en accepts the tag in the same cycle.
  - Dropping en mid-XFER still completes all beats.
- **Reset mid-transfer:** rst after 2 of 5 beats.
  - Next cycle: m_tvalid = 0, busy = 0, all status = 0.
  - A new tag (0, dest 1) after reset delivers 1 beat correctly.
